// File: rtl/framebuffer_scanout.sv
// Raster scan-out of a 1bpp framebuffer into a VGA-style hsync/vsync/de/pixel stream.
// Define SCANOUT_BORDER_EN to OR a one-pixel border into the visible area.
module framebuffer_scanout #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int ADDR_WIDTH = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] fb_rd_addr,
    input  logic                  fb_rd_data,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  pixel_out,
    output logic                  frame_start,
    output logic                  busy
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_AL   = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_AL   = VW'(V_ACTIVE - 1);

    localparam logic [31:0] HA       = 32'(H_ACTIVE);
    localparam logic [31:0] VA       = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [HW-1:0]         h_q, h_d;
    logic [VW-1:0]         v_q, v_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic hsync_q, vsync_q, de_q, fs_q;

    logic h_last, v_last, frame_last, active, last_pix, run;

    assign h_last     = (h_q == H_LAST);
    assign v_last     = (v_q == V_LAST);
    assign frame_last = h_last && v_last;
    assign active     = (32'(h_q) < HA) && (32'(v_q) < VA);
    assign last_pix   = (h_q == H_AL) && (v_q == V_AL);
    assign run        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        h_d     = '0;
        v_d     = '0;
        addr_d  = '0;
        unique case (state_q)
            IDLE:  if (enable) state_d = RUN;
            RUN:   if (!enable) state_d = frame_last ? IDLE : DRAIN;
            DRAIN: begin
                if (enable) state_d = RUN;
                else if (frame_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (run) begin
            h_d    = h_last ? '0 : h_q + HW'(1);
            v_d    = v_q;
            addr_d = addr_q;
            if (h_last) v_d = v_last ? '0 : v_q + VW'(1);
            // Address parks on the last pixel through blanking, restarts at wrap.
            if (frame_last) addr_d = '0;
            else if (active && !last_pix) addr_d = addr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
        end
    end

    // Output stage: one register of decode to match the framebuffer read latency.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= !((32'(h_q) >= HS_START) && (32'(h_q) < HS_END));
            vsync_q <= !((32'(v_q) >= VS_START) && (32'(v_q) < VS_END));
            de_q    <= active;
            fs_q    <= (h_q == '0) && (v_q == '0);
        end
    end

`ifdef SCANOUT_BORDER_EN
    logic border_q;

    always_ff @(posedge clk) begin
        if (reset || !run) begin
            border_q <= 1'b0;
        end else begin
            border_q <= active && (h_q == '0 || h_q == H_AL ||
                                   v_q == '0 || v_q == V_AL);
        end
    end

    assign pixel_out = de_q & (fb_rd_data | border_q);
`else
    assign pixel_out = de_q & fb_rd_data;
`endif

    assign fb_rd_addr  = addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign busy        = run;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Scoreboard bench for framebuffer_scanout with a small 4x3 raster.
// Stimulus pushes expected outputs per edge; a monitor pops and compares.
module tb_framebuffer_scanout;
    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int AW = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
`ifdef SCANOUT_BORDER_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [AW-1:0] fb_rd_addr;
    logic          fb_rd_data;
    logic          hsync, vsync, de, pixel_out, frame_start, busy;
    logic [15:0]   pat = 16'h0AAA;

    int errors = 0;
    int checks = 0;
    int cyc_n  = 0;

    logic [9:0] expq[$];
    logic [3:0] obsq[$];
    bit         rec = 1'b0;

    int m_st = 0;
    int m_p  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) fb_rd_data <= pat[fb_rd_addr];

    framebuffer_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .fb_rd_addr(fb_rd_addr),
        .fb_rd_data(fb_rd_data),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .pixel_out(pixel_out),
        .frame_start(frame_start),
        .busy(busy)
    );

    // Read address a raster position presents: v*HA+h, parked on the
    // last pixel of the frame once past it.
    function automatic int addr_of(input int p);
        int h, v, a;
        h = p % HT;
        v = p / HT;
        if (v >= VA) return HA * VA - 1;
        a = v * HA + ((h < HA) ? h : HA);
        if (a > HA * VA - 1) a = HA * VA - 1;
        return a;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step(input logic rst, input logic en);
        logic ehs, evs, ede, efs, ebd, epx, last;
        int   h, v, pa, nst;
        @(negedge clk);
        if (rec) obsq.push_back({de, hsync, vsync, frame_start});
        reset  = rst;
        enable = en;
        ehs = 1'b1; evs = 1'b1; ede = 1'b0; efs = 1'b0; ebd = 1'b0; epx = 1'b0;
        pa = addr_of(m_p);
        if (rst) begin
            m_st = 0;
            m_p  = 0;
        end else begin
            if (m_st != 0) begin
                h   = m_p % HT;
                v   = m_p / HT;
                ede = (h < HA) && (v < VA);
                ehs = !((h >= HA + HF) && (h < HA + HF + HS));
                evs = !((v >= VA + VF) && (v < VA + VF + VS));
                efs = (m_p == 0);
                ebd = ede && (h == 0 || h == HA - 1 || v == 0 || v == VA - 1);
                epx = ede && (pat[pa] || (BORDER && ebd));
            end
            last = (m_p == FRAME - 1);
            nst  = m_st;
            case (m_st)
                0: if (en) nst = 1;
                1: if (!en) nst = last ? 0 : 2;
                default: if (en) nst = 1; else if (last) nst = 0;
            endcase
            m_p  = (m_st == 0 || last) ? 0 : m_p + 1;
            m_st = nst;
        end
        expq.push_back({4'(addr_of(m_p)), ehs, evs, ede, epx, efs, m_st != 0});
    endtask

    task automatic steps(input int n, input logic rst, input logic en);
        for (int i = 0; i < n; i++) step(rst, en);
    endtask

    initial begin
        logic [9:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = {fb_rd_addr, hsync, vsync, de, pixel_out, frame_start, busy};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL cycle%0d {addr,hs,vs,de,pix,fs,busy}: got %b, expected %b",
                             cyc_n, a, e);
                end
            end
        end
    end

    initial begin
        int i0, i1, nde, nhs, nvs, hs0, vs0;
        logic [3:0] ob[$];
        steps(3, 1'b1, 1'b0);
        steps(2, 1'b0, 1'b0);

        rec = 1'b1;
        steps(2 * FRAME + 4, 1'b0, 1'b1);
        rec = 1'b0;

        // Drop enable mid-frame: frame completes, then idle.
        steps(60, 1'b0, 1'b0);

        // New pattern while idle; re-raise enable during drain.
        pat = 16'h03C5;
        steps(12, 1'b0, 1'b1);
        steps(10, 1'b0, 1'b0);
        steps(40, 1'b0, 1'b1);
        steps(50, 1'b0, 1'b0);

        // Reset inside the active region, then a fresh frame.
        steps(10, 1'b0, 1'b1);
        step(1'b1, 1'b1);
        steps(20, 1'b0, 1'b1);
        steps(50, 1'b0, 1'b0);

        @(posedge clk);
        #2;
        chk("scoreboard drained", expq.size(), 0);

        ob = obsq;
        i0 = -1;
        i1 = -1;
        for (int k = 0; k < ob.size(); k++) begin
            if (ob[k][0]) begin
                if (i0 < 0) i0 = k;
                else if (i1 < 0) i1 = k;
            end
        end
        chk("first frame_start seen", int'(i0 >= 0), 1);
        chk("frame period", i1 - i0, FRAME);
        nde = 0; nhs = 0; nvs = 0; hs0 = -1; vs0 = -1;
        if (i0 >= 0 && i0 + FRAME <= ob.size()) begin
            for (int k = i0; k < i0 + FRAME; k++) begin
                if (ob[k][3]) nde++;
                if (!ob[k][2]) begin
                    nhs++;
                    if (hs0 < 0) hs0 = k - i0;
                end
                if (!ob[k][1]) begin
                    nvs++;
                    if (vs0 < 0) vs0 = k - i0;
                end
            end
        end
        chk("de cycles per frame", nde, HA * VA);
        chk("hsync low clocks per frame", nhs, HS * VT);
        chk("vsync low clocks per frame", nvs, VS * HT);
        chk("hsync low offset", hs0, HA + HF);
        chk("vsync low offset", vs0, (VA + VF) * HT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/framebuffer_scanout.md
# framebuffer_scanout

Read-side consumer of the simple dual-port framebuffer: walks the 1-bit-per-pixel frame in raster order through the framebuffer read port and emits a VGA-style pixel stream (hsync, vsync, data-enable, pixel). Sits opposite the line-drawing writer, which fills the framebuffer through the write port. Handles start/stop at frame boundaries and compensates the framebuffer's one-cycle read latency so that sync, data-enable and pixel stay aligned.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (clocks)
- H_SYNC, 96: hsync pulse width (clocks)
- H_BP, 48: horizontal back porch (clocks)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vsync pulse width (lines)
- V_BP, 33: vertical back porch (lines)
- ADDR_WIDTH, 19: framebuffer address width; H_ACTIVE*V_ACTIVE must not exceed 2^ADDR_WIDTH

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  level request to scan; sampled as described under Operation
- fb_rd_addr  out  ADDR_WIDTH  framebuffer read address, registered
- fb_rd_data  in  1  framebuffer read data, valid one cycle after fb_rd_addr
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- de  out  1  data enable, high on visible pixels
- pixel_out  out  1  pixel color, 0 whenever de=0
- frame_start  out  1  one-cycle pulse aligned with the output of pixel (0,0)
- busy  out  1  high while the FSM is in RUN or DRAIN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- FSM states:
  - IDLE: counters and address held at 0; outputs at reset values. IDLE->RUN when enable=1.
  - RUN: h_cnt counts 0..H_TOTAL-1 and wraps; v_cnt increments on each h wrap and wraps at V_TOTAL-1. RUN->DRAIN when enable=0.
  - DRAIN: same counting as RUN. DRAIN->RUN if enable returns to 1. DRAIN->IDLE on the last counter position (h=H_TOTAL-1, v=V_TOTAL-1), after the 1-cycle output stage has flushed.
  - A frame is never truncated by enable; only reset truncates it.
- Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Address: linear v*H_ACTIVE+h, generated incrementally with no multiplier.
  - Increments by 1 on each active pixel and holds outside the active region.
  - Returns to 0 at frame wrap.
- Sync decode:
  - hsync low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync low for V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC.
- Alignment: hsync, vsync, de and frame_start come from a 1-stage register of the counter decode, so they line up with the returned fb_rd_data.
- Reset at any time: on the next edge FSM=IDLE, counters=0, address=0, all outputs at reset values. An in-flight read is discarded.

## Timing
- Reset values: fb_rd_addr=0, hsync=1, vsync=1, de=0, pixel_out=0, frame_start=0, busy=0.
- Start: enable sampled 1 at edge N.
  - Edge N: FSM enters RUN and busy=1.
  - Cycle after N: counters=(0,0) and fb_rd_addr=0.
  - One cycle later: de=1, frame_start=1, pixel_out=mem[0].
- Steady-state latency: pixel for fb_rd_addr=A appears on pixel_out exactly 1 cycle after A is presented.
- One pixel per clock, no stalls. Frame period is H_TOTAL*V_TOTAL cycles (420000 at defaults).
- Stop: busy falls on the cycle after the last output-stage cycle of the frame in which enable dropped.

## Configuration
- SCANOUT_BORDER_EN defined: pixel_out = fb_rd_data OR border.
  - border is 1 when the output pixel has h=0, h=H_ACTIVE-1, v=0 or v=V_ACTIVE-1.
  - Only applies while de=1. Address and timing are unchanged.
- SCANOUT_BORDER_EN not defined: pixel_out = fb_rd_data when de=1, else 0.

## Test plan
- Reset then enable=1 with defaults, memory all 0 except mem[0]=1 and mem[307199]=1 -> frame_start pulse on the same cycle pixel_out=1; second pixel_out=1 is the last de cycle; 307200 de cycles per frame.
- Count per line and per frame at defaults -> hsync low for exactly 96 clocks starting 656 clocks after line start; vsync low for 1600 clocks (2 lines) starting at line 490; frame period 420000.
- Small parameters (H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=3, V_FP=V_SYNC=V_BP=1) with mem[i]=i[0] -> pixel_out sequence 0,1,0,1 on each line; fb_rd_addr runs 0..11 and then returns to 0.
- Drop enable mid-frame (small parameters) -> frame completes, busy falls 1 cycle after the final counter position, and outputs hold reset values afterward. Re-raise enable during DRAIN -> no gap, next frame starts immediately.
- Assert reset during the active region -> next edge: de=0, hsync=vsync=1, fb_rd_addr=0, busy=0. Re-enable -> a fresh frame begins at address 0.
- With SCANOUT_BORDER_EN defined and memory all 0 (small parameters) -> pixel_out=1 only on the first and last rows and the first and last columns.
